// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the asynchronous FIFO and its read-side packer.
package fifo_pkg;

  localparam int DSIZE_DEF   = 32;
  localparam int RATIO_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  // Width that can hold a word count of 0..ratio inclusive.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// Saturating idle counter: counts enabled cycles up to TIMEOUT and flags expiry.
module fifo_rd_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic rclk,
  input  logic rrst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      idle <= '0;
    end else if (clr) begin
      idle <= '0;
    end else if (en && idle != TW'(TIMEOUT)) begin
      idle <= idle + TW'(1);
    end
  end

  assign expire = (idle == TW'(TIMEOUT));

endmodule

// File: rtl/fifo_rd_pack.sv
// Read-side packer: pops RATIO FIFO words and presents them as one wide valid/ready word.
// Define FIFO_RD_PACK_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module fifo_rd_pack
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int RATIO = RATIO_DEF,
`ifdef FIFO_RD_PACK_TIMEOUT_EN
  parameter int TIMEOUT = TIMEOUT_DEF,
`endif
  parameter int CW = cnt_width(RATIO)
) (
  input  logic                   rclk,
  input  logic                   rrst,
  input  logic                   rempty,
  input  logic [DSIZE-1:0]       rdata,
  output logic                   rinc,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DSIZE*RATIO-1:0] m_data,
  output logic [CW-1:0]          m_count
);

  localparam int LW = $clog2(RATIO);
  localparam int WW = DSIZE * RATIO;

  logic [LW-1:0]    cnt;
  logic [DSIZE-1:0] lane [RATIO-1];
  logic             out_free;
  logic             last;
  logic             complete;
  logic [WW-1:0]    full_word;

  assign out_free = !m_valid || m_ready;
  assign last     = (cnt == LW'(RATIO - 1));
  // The completing pop needs somewhere to go; earlier lanes fill regardless of the sink.
  assign rinc     = !rempty && (!last || out_free);
  assign complete = rinc && last;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full_word = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      full_word[i*DSIZE +: DSIZE] = lane[i];
    end
    full_word[WW-1 -: DSIZE] = rdata;
  end

`ifdef FIFO_RD_PACK_TIMEOUT_EN
  logic          expire;
  logic          flush;
  logic [WW-1:0] part_word;

  // A pop always wins over a pending flush; the pop then clears the idle count.
  assign flush = expire && out_free && !rinc;

  fifo_rd_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .rclk   (rclk),
    .rrst   (rrst),
    .clr    (rinc || cnt == '0 || flush),
    .en     (cnt != '0),
    .expire (expire)
  );

  // Lanes at or above cnt hold stale data from an earlier word and must read as zero.
  always_comb begin
    part_word = '0;
    for (int i = 0; i < RATIO - 1; i++) begin
      if (LW'(i) < cnt) part_word[i*DSIZE +: DSIZE] = lane[i];
    end
  end
`endif

  // NOTE: the lane array is small flop storage with defined reset contents, so it is reset too.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      cnt     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_count <= '0;
      for (int i = 0; i < RATIO - 1; i++) lane[i] <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (complete) begin
        m_valid <= 1'b1;
        m_data  <= full_word;
        m_count <= CW'(RATIO);
        cnt     <= '0;
      end else if (rinc) begin
        for (int i = 0; i < RATIO - 1; i++) begin
          if (cnt == LW'(i)) lane[i] <= rdata;
        end
        cnt <= cnt + LW'(1);
      end
`ifdef FIFO_RD_PACK_TIMEOUT_EN
      else if (flush) begin
        m_valid <= 1'b1;
        m_data  <= part_word;
        m_count <= CW'(cnt);
        cnt     <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Self-checking bench for fifo_rd_pack: a FIFO queue drives the packer, a word-list model predicts outputs.
module tb_fifo_rd_pack;

  localparam int DW = 32;
  localparam int R  = 4;
  localparam int WW = DW * R;
  localparam int CW = 3;
`ifdef FIFO_RD_PACK_TIMEOUT_EN
  localparam int TIMEOUT = 16;
`endif

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic          m_ready;
  logic [WW-1:0] m_data;
  logic [CW-1:0] m_count;

  fifo_rd_pack dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rempty  (rempty),
    .rdata   (rdata),
    .rinc    (rinc),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_count (m_count)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and stimulus knobs
  logic [DW-1:0] fq[$];
  bit            gate;
  bit            rdy;
  int            obs_pops;

  // Reference model: words collected so far plus the one-deep output slot
  logic [DW-1:0] acc[$];
  bit            exp_valid;
  logic [WW-1:0] exp_data;
  int            exp_count;
  int            idle;

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack(input logic [DW-1:0] w[$]);
    logic [WW-1:0] r = '0;
    for (int i = 0; i < w.size(); i++) r[i*DW +: DW] = w[i];
    return r;
  endfunction

  task automatic model_reset();
    acc.delete();
    exp_valid = 0;
    exp_data  = '0;
    exp_count = 0;
    idle      = 0;
  endtask

  // One clock cycle: apply inputs, check against the model, advance both at the edge.
  task automatic tick();
    bit pop, free, flush;
    rempty  = gate || (fq.size() == 0);
    rdata   = (fq.size() != 0) ? fq[0] : '0;
    m_ready = rdy;
    #1;
    free = !exp_valid || rdy;
    pop  = !rempty && (acc.size() != R - 1 || free);
    check("rinc", {127'b0, rinc}, {127'b0, pop});
    check("m_valid", {127'b0, m_valid}, {127'b0, exp_valid});
    if (exp_valid) begin
      check("m_data", m_data, exp_data);
      check("m_count", WW'(m_count), WW'(exp_count));
    end
    if (rinc === 1'b1) obs_pops++;
    flush = 0;
`ifdef FIFO_RD_PACK_TIMEOUT_EN
    flush = (idle == TIMEOUT) && free && !pop && acc.size() != 0;
`endif
    @(posedge rclk);
    if (exp_valid && rdy) exp_valid = 0;
    if (pop) begin
      acc.push_back(fq.pop_front());
      if (acc.size() == R) begin
        exp_data  = pack(acc);
        exp_count = R;
        exp_valid = 1;
        acc.delete();
      end
    end else if (flush) begin
      exp_data  = pack(acc);
      exp_count = acc.size();
      exp_valid = 1;
      acc.delete();
    end
    if (pop || acc.size() == 0) idle = 0;
`ifdef FIFO_RD_PACK_TIMEOUT_EN
    else if (idle < TIMEOUT) idle++;
`endif
    @(negedge rclk);
  endtask

  task automatic do_reset();
    gate   = 1;
    rempty = 1'b1;
    rrst   = 1'b1;
    #1;
    model_reset();
    fq.delete();
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w[12];
    int p0;

    // Reset with an empty FIFO
    rrst = 1'b1; gate = 1; rdy = 0; obs_pops = 0;
    rempty = 1'b1; rdata = '0; m_ready = 1'b0;
    model_reset();
    #3;
    check("rst_rinc", {127'b0, rinc}, '0);
    check("rst_m_valid", {127'b0, m_valid}, '0);
    check("rst_m_count", WW'(m_count), '0);
    check("rst_m_data", m_data, '0);
    @(negedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_no_pop", WW'(obs_pops), '0);

    // Back-to-back 1..8, sink always ready
    gate = 0; rdy = 1;
    for (int i = 1; i <= 8; i++) fq.push_back(DW'(i));
    for (int i = 0; i < 4; i++) tick();
    check("first_valid", {127'b0, m_valid}, 128'd1);
    check("first_data", m_data, 128'h00000004_00000003_00000002_00000001);
    check("first_count", WW'(m_count), 128'd4);
    for (int i = 0; i < 4; i++) tick();
    check("second_data", m_data, 128'h00000008_00000007_00000006_00000005);
    check("no_idle_pops", WW'(obs_pops), 128'd8);
    tick();

    // Back-pressure with 12 words available
    rdy = 0;
    p0  = obs_pops;
    for (int i = 0; i < 12; i++) begin
      w[i] = $urandom;
      fq.push_back(w[i]);
    end
    for (int i = 0; i < 10; i++) tick();
    check("bp_pops", WW'(obs_pops - p0), 128'd7);
    check("bp_stable", m_data, {w[3], w[2], w[1], w[0]});
    rdy = 1;
    tick();
    check("bp_8th_pop", WW'(obs_pops - p0), 128'd8);
    check("bp_reload", m_data, {w[7], w[6], w[5], w[4]});
    for (int i = 0; i < 5; i++) tick();
    check("bp_all_pops", WW'(obs_pops - p0), 128'd12);
    check("bp_third", m_data, {w[11], w[10], w[9], w[8]});
    tick();

    // rempty toggling every other cycle
    for (int i = 0; i < 16; i++) fq.push_back($urandom);
    for (int i = 0; i < 40; i++) begin
      gate = (i % 2) != 0;
      tick();
    end
    check("toggle_drained", WW'(fq.size()), '0);

    // Randomized traffic and back-pressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) fq.push_back($urandom);
      gate = ($urandom_range(0, 3) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Partial word followed by a long idle stretch
    do_reset();
    gate = 0; rdy = 0;
    w[0] = $urandom; w[1] = $urandom;
    fq.push_back(w[0]); fq.push_back(w[1]);
    for (int i = 0; i < 25; i++) tick();
`ifdef FIFO_RD_PACK_TIMEOUT_EN
    check("to_valid", {127'b0, m_valid}, 128'd1);
    check("to_count", WW'(m_count), 128'd2);
    check("to_data", m_data, {64'b0, w[1], w[0]});
`else
    check("to_no_flush", {127'b0, m_valid}, '0);
`endif

    // Reset mid-operation with three lanes filled and an output word pending
    do_reset();
    gate = 0; rdy = 0;
    for (int i = 0; i < 7; i++) fq.push_back($urandom);
    for (int i = 0; i < 7; i++) tick();
    check("pre_rst_valid", {127'b0, m_valid}, 128'd1);
    #2;
    rrst = 1'b1; gate = 1; rempty = 1'b1;
    #1;
    check("mid_rst_valid", {127'b0, m_valid}, '0);
    check("mid_rst_count", WW'(m_count), '0);
    check("mid_rst_data", m_data, '0);
    check("mid_rst_rinc", {127'b0, rinc}, '0);
    model_reset();
    fq.delete();
    @(negedge rclk);
    rrst = 1'b0;
    gate = 0; rdy = 1;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      fq.push_back(w[i]);
    end
    for (int i = 0; i < 4; i++) tick();
    check("post_rst_data", m_data, {w[3], w[2], w[1], w[0]});
    check("post_rst_count", WW'(m_count), 128'd4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
